// File: rtl/pll_recfg_pkg.sv
// Shared constants for the PLL dynamic-reconfiguration controller: MD opcodes,
// controller state encodings and error codes.
package pll_recfg_pkg;

  localparam logic [1:0] MD_NOP     = 2'b00;
  localparam logic [1:0] MD_WRITE   = 2'b01;
  localparam logic [1:0] MD_READ    = 2'b10;
  localparam logic [1:0] MD_SETADDR = 2'b11;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_RST_WAIT  = 4'd1;
  localparam logic [3:0] ST_FETCH     = 4'd2;
  localparam logic [3:0] ST_SETADDR   = 4'd3;
  localparam logic [3:0] ST_WRITE     = 4'd4;
  localparam logic [3:0] ST_VERIFY    = 4'd5;
  localparam logic [3:0] ST_RELEASE   = 4'd6;
  localparam logic [3:0] ST_WAIT_LOCK = 4'd7;
  localparam logic [3:0] ST_DONE      = 4'd8;
  localparam logic [3:0] ST_ABORT     = 4'd9;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_VERIFY   = 2'b01;
  localparam logic [1:0] ERR_LOCK_TMO = 2'b10;

  // States during which the PLL is held in reset while the MD port is programmed.
  function automatic logic holds_pll_reset(input logic [3:0] st);
    return (st == ST_RST_WAIT) || (st == ST_FETCH) || (st == ST_SETADDR) ||
           (st == ST_WRITE) || (st == ST_VERIFY);
  endfunction

endpackage

// File: rtl/pll_lock_qual.sv
// Lock qualifier: synchronizes the raw PLL lock, demands LOCK_STABLE consecutive
// high samples while run is set, and flags a timeout after LOCK_TMO run cycles.
module pll_lock_qual #(
  parameter int LOCK_STABLE = 64,
  parameter int LOCK_TMO    = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_lock,
  input  logic start,
  input  logic run,
  output logic locked,
  output logic timeout
);

  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TMO);

  logic [1:0]    sync_q, sync_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          locked_q, locked_d;

  always_comb begin
    sync_d   = {sync_q[0], pll_lock};
    stab_d   = stab_q;
    tmo_d    = tmo_q;
    locked_d = locked_q;
    if (start) begin
      stab_d   = '0;
      tmo_d    = '0;
      locked_d = 1'b0;
    end else begin
      // Any low synced sample restarts the stability window and drops lock.
      if (!sync_q[1]) begin
        stab_d   = '0;
        locked_d = 1'b0;
      end else if (run && (stab_q != SW'(LOCK_STABLE))) begin
        stab_d = stab_q + 1'b1;
        if (stab_q == SW'(LOCK_STABLE - 1)) locked_d = 1'b1;
      end
      if (run) tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stab_q   <= '0;
      tmo_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stab_q   <= stab_d;
      tmo_q    <= tmo_d;
      locked_q <= locked_d;
    end
  end

  assign locked  = locked_q & sync_q[1];
  assign timeout = run && (tmo_q == TW'(LOCK_TMO - 1));

endmodule

// File: rtl/pll_recfg_ctrl.sv
// PLL dynamic-config sequencer: streams (addr,data) beats into the MD port with the PLL
// held in reset, then qualifies lock. Define PLL_RECFG_VERIFY_EN for read-back verify.
module pll_recfg_ctrl
  import pll_recfg_pkg::*;
#(
  parameter int RST_HOLD    = 16,
  parameter int RD_LAT      = 2,
  parameter int LOCK_STABLE = 64,
  parameter int LOCK_TMO    = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_data,
  input  logic       cfg_last,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       pll_locked,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       mdclk,
  output logic [1:0] mdopc,
  output logic       mdainc,
  output logic [7:0] mdwdi,
  input  logic [7:0] mdrdo,
  output logic [3:0] dbg_state
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  // Verify step at which mdrdo is sampled: read-op mdclk rise is step 4.
  localparam logic [3:0] V_CMP = 4'(4 + RD_LAT);

  logic [3:0]    state_q, state_d;
  logic [3:0]    ph_q, ph_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0]    addr_q, addr_d, data_q, data_d, cur_addr_q, cur_addr_d;
  logic          last_q, last_d, cur_vld_q, cur_vld_d, cfg_ready_q, cfg_ready_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          accept, qual_locked, qual_timeout;
  logic [3:0]    after_write;

  // cfg_valid/cfg_ready: a beat transfers on any clk edge where both are high; cfg_addr,
  // cfg_data and cfg_last must be stable while cfg_valid is high and not yet accepted.
  assign accept      = cfg_valid & cfg_ready_q;
  assign after_write = last_q ? ST_RELEASE : ST_FETCH;

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    hold_d     = hold_q;
    addr_d     = addr_q;
    data_d     = data_q;
    last_d     = last_q;
    cur_addr_d = cur_addr_q;
    cur_vld_d  = cur_vld_q;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        addr_d     = cfg_addr;
        data_d     = cfg_data;
        last_d     = cfg_last;
        cur_vld_d  = 1'b0;
        err_code_d = ERR_NONE;
        hold_d     = '0;
        state_d    = ST_RST_WAIT;
      end
      ST_RST_WAIT: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HW'(RST_HOLD - 1)) begin
          ph_d    = '0;
          state_d = ST_SETADDR;
        end
      end
      ST_FETCH: if (accept) begin
        addr_d  = cfg_addr;
        data_d  = cfg_data;
        last_d  = cfg_last;
        ph_d    = '0;
        state_d = (cur_vld_q && (cfg_addr == cur_addr_q)) ? ST_WRITE : ST_SETADDR;
      end
      ST_SETADDR: begin
        ph_d = ph_q + 4'd1;
        if (ph_q == 4'd2) begin
          cur_addr_d = addr_q;
          cur_vld_d  = 1'b1;
          ph_d       = '0;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ph_d = ph_q + 4'd1;
        if (ph_q == 4'd2) begin
          cur_addr_d = cur_addr_q + 8'd1;
          ph_d       = '0;
`ifdef PLL_RECFG_VERIFY_EN
          state_d    = ST_VERIFY;
`else
          state_d    = after_write;
`endif
        end
      end
`ifdef PLL_RECFG_VERIFY_EN
      ST_VERIFY: begin
        ph_d = ph_q + 4'd1;
        if (ph_q == 4'd2) cur_addr_d = addr_q;
        if (ph_q == V_CMP) begin
          cur_addr_d = addr_q + 8'd1;
          ph_d       = '0;
          if (mdrdo != data_q) begin
            err_code_d = ERR_VERIFY;
            state_d    = ST_ABORT;
          end else begin
            state_d = after_write;
          end
        end
      end
`endif
      ST_RELEASE: state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (qual_locked) begin
          state_d = ST_DONE;
        end else if (qual_timeout) begin
          err_code_d = ERR_LOCK_TMO;
          state_d    = ST_ABORT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cfg_ready_d = (state_d == ST_IDLE) || (state_d == ST_FETCH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      hold_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      cur_addr_q  <= '0;
      cur_vld_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      hold_q      <= hold_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      last_q      <= last_d;
      cur_addr_q  <= cur_addr_d;
      cur_vld_q   <= cur_vld_d;
      err_code_q  <= err_code_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  // Each MD op: step 0 drives with mdclk low, step 1 raises mdclk, step 2 returns to nop.
  always_comb begin
    mdopc  = MD_NOP;
    mdwdi  = '0;
    mdainc = 1'b0;
    mdclk  = 1'b0;
    case (state_q)
      ST_SETADDR: if (ph_q != 4'd2) begin
        mdopc = MD_SETADDR;
        mdwdi = addr_q;
        mdclk = ph_q[0];
      end
      ST_WRITE: if (ph_q != 4'd2) begin
        mdopc  = MD_WRITE;
        mdwdi  = data_q;
        mdainc = 1'b1;
        mdclk  = ph_q[0];
      end
`ifdef PLL_RECFG_VERIFY_EN
      ST_VERIFY: begin
        if (ph_q < 4'd2) begin
          mdopc = MD_SETADDR;
          mdwdi = addr_q;
          mdclk = ph_q[0];
        end else if ((ph_q == 4'd3) || (ph_q == 4'd4)) begin
          mdopc  = MD_READ;
          mdainc = 1'b1;
          mdclk  = (ph_q == 4'd4);
        end
      end
`endif
      default: ;
    endcase
  end

`ifndef PLL_RECFG_VERIFY_EN
  logic unused_verify;
  assign unused_verify = ^{mdrdo, V_CMP};
`endif

  pll_lock_qual #(
    .LOCK_STABLE(LOCK_STABLE),
    .LOCK_TMO   (LOCK_TMO)
  ) u_lock_qual (
    .clk     (clk),
    .rst     (reset),
    .pll_lock(pll_lock),
    .start   ((state_q == ST_RELEASE) || ((state_q == ST_IDLE) && accept)),
    .run     (state_q == ST_WAIT_LOCK),
    .locked  (qual_locked),
    .timeout (qual_timeout)
  );

  assign cfg_ready  = cfg_ready_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = (state_q == ST_ABORT);
  assign err_code   = err_code_q;
  assign pll_locked = qual_locked;
  assign pll_reset  = holds_pll_reset(state_q);
  assign dbg_state  = state_q;

endmodule
